register_file: RTL and testbench

- Multi-port general-purpose register file for the CPU datapath: 2^REG_ADDR_SIZE registers of WORD_SIZE bits.
- Provides one synchronous write port and two asynchronous (combinational) read ports.
- Feeds ALU operands (out1/out2) and accepts writeback data.
- Register 0 is hard-wired to zero, RISC style.

---
 rtl/register_file.sv | 45 ++++
 tb/tb_register_file.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports. Register 0 is hard-wired to zero.
module register_file #(
   parameter int unsigned WORD_SIZE     = 64,
   parameter int unsigned REG_ADDR_SIZE = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [REG_ADDR_SIZE-1:0] write,
   input  logic [REG_ADDR_SIZE-1:0] r1,
   input  logic [REG_ADDR_SIZE-1:0] r2,
   input  logic [WORD_SIZE-1:0]     data,
   output logic [WORD_SIZE-1:0]     out1,
   output logic [WORD_SIZE-1:0]     out2
);

   localparam int unsigned NUM_REGS = 2 ** REG_ADDR_SIZE;

   logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
   logic                 wr_valid;

   // Writes to address 0 are dropped so entry 0 stays at its reset value of zero.
   assign wr_valid = en && (write != '0);

   // Register storage: asynchronous clear, single write per rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_valid) begin
         regs_q[write] <= data;
      end
   end

   // Combinational read ports; no write-to-read bypass.
   always_comb begin
      out1 = '0;
      out2 = '0;
      if (r1 != '0) out1 = regs_q[r1];
      if (r2 != '0) out2 = regs_q[r2];
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// randomized traffic compared against an array-based reference model.
module tb_register_file;

   localparam int unsigned W = 64;
   localparam int unsigned A = 4;
   localparam int unsigned N = 16;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [A-1:0] write;
   logic [A-1:0] r1;
   logic [A-1:0] r2;
   logic [W-1:0] data;
   logic [W-1:0] out1;
   logic [W-1:0] out2;

   logic [W-1:0] model [N];
   int           checks;
   int           failures;

   register_file #(
      .WORD_SIZE    (W),
      .REG_ADDR_SIZE(A)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .write(write),
      .r1   (r1),
      .r2   (r2),
      .data (data),
      .out1 (out1),
      .out2 (out2)
   );

   // Period 20, first rising edge at t=10.
   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [W-1:0] exp_read(input logic [A-1:0] a);
      if (a == 0) return '0;
      return model[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) model[i] = '0;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, apply the architectural write rule, settle 1 time unit.
   task automatic tick();
      @(posedge clk);
      if (rst_n && en && write != 0) model[write] = data;
      #1;
   endtask

   initial begin
      logic [A-1:0] ra;
      checks   = 0;
      failures = 0;
      model_clear();
      rst_n = 1'b0;
      en    = 1'b0;
      write = '0;
      r1    = 4'd1;
      r2    = 4'd15;
      data  = '0;

      #2;
      check("reset_out1", out1, 64'd0);
      check("reset_out2", out2, 64'd0);
      #3;
      rst_n = 1'b1;

      // Basic write/read
      en = 1'b1; write = 4'd1; data = 64'd67; r1 = 4'd1; r2 = 4'd2;
      tick();
      check("basic_out1", out1, 64'd67);
      check("basic_out2", out2, 64'd0);
      write = 4'd2; data = 64'd41;
      tick();
      check("basic2_out2", out2, 64'd41);
      check("basic2_out1", out1, 64'd67);

      // Zero register
      write = 4'd0; data = 64'd42;
      tick();
      r2 = 4'd0;
      #1;
      check("zero_out2", out2, 64'd0);
      r2 = 4'd2;
      #1;
      check("zero_keep1", out1, 64'd67);
      check("zero_keep2", out2, 64'd41);

      // Top address, overwrite, no bypass, data sampled only at edge
      write = 4'd15; data = 64'd21;
      tick();
      write = 4'd15; data = 64'd99; r1 = 4'd15;
      #1;
      check("top_old", out1, 64'd21);
      #2;
      data = 64'd22;
      #1;
      check("top_still_old", out1, 64'd21);
      tick();
      check("top_new", out1, 64'd22);
      check("top_out2", out2, 64'd41);

      // Write enable low
      en = 1'b0; write = 4'd3; data = 64'hDEADBEEF;
      repeat (3) tick();
      r1 = 4'd3;
      #1;
      check("en_low", out1, 64'd0);

      // Same-address reads
      r1 = 4'd15; r2 = 4'd15;
      #1;
      check("same_out1", out1, 64'd22);
      check("same_out2", out2, 64'd22);

      // Asynchronous reset between edges
      r1 = 4'd1;
      #1;
      check("pre_rst_out1", out1, 64'd67);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check("async_rst_out1", out1, 64'd0);
      check("async_rst_out2", out2, 64'd0);
      en = 1'b1; write = 4'd1; data = 64'd77;
      tick();
      check("rst_write_ignored", out1, 64'd0);
      #4;
      rst_n = 1'b1;
      data = 64'd5;
      tick();
      check("post_rst_write", out1, 64'd5);

      // Randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         en    = 1'($urandom_range(0, 1));
         write = A'($urandom);
         ra    = A'($urandom);
         r1    = ra;
         r2    = ($urandom_range(0, 5) == 0) ? ra : A'($urandom);
         data  = {$urandom, $urandom};
         #1;
         check("rand_pre_out1", out1, exp_read(r1));
         check("rand_pre_out2", out2, exp_read(r2));
         tick();
         check("rand_post_out1", out1, exp_read(r1));
         check("rand_post_out2", out2, exp_read(r2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
